add_accum_16: RTL and testbench
===============================

Name: add_accum_16

Overview:
- Sequential accumulator wrapped around the team's 16-bit adder (s16_bit_adder).
- Drives the adder's operands from a running accumulator and an incoming operand stream, then registers the adder's sum and carry back into the accumulator.
- Sits directly upstream and downstream of the adder.
- Converts the combinational adder into a streaming multi-operand summer with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, datapath width; must match the adder instance.
- CNT_W, 8, width of the operand counter and the carry counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- start  input  1  one-cycle pulse; begins a new accumulation (honoured in IDLE only).
- in_valid  input  1  operand valid.
- in_ready  output  1  operand accepted when in_valid && in_ready.
- in_data  input  WIDTH  operand.
- in_last  input  1  marks the final operand of the group.
- add_a  output  WIDTH  adder operand A = accumulator register.
- add_b  output  WIDTH  adder operand B = in_data.
- add_cin  output  1  adder carry_in; constant 0.
- add_sum  input  WIDTH  adder sum.
- add_cout  input  1  adder carry_out.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed when out_valid && out_ready.
- out_sum  output  WIDTH  final accumulator value.
- out_carries  output  CNT_W  number of accepted beats that produced add_cout=1 (saturating).
- out_ops  output  CNT_W  number of operands accepted (wrapping).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; acc, carry_cnt and op_cnt go to 0.
  - in_ready=0, out_valid=0, out_sum=0, out_carries=0, out_ops=0.
  - Reset overrides every other input in the same cycle. A reset mid-group discards the partial sum; no result is emitted.
- Combinational outputs: add_a=acc, add_b=in_data, add_cin=0. The adder path is purely combinational within one cycle.
- State machine: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 → acc, carry_cnt, op_cnt cleared; next state ACCUM.
- ACCUM:
  - in_ready=1.
  - On an accepted beat:
    - acc <= add_sum.
    - carry_cnt += add_cout, saturating at 2^CNT_W-1.
    - op_cnt <= op_cnt+1, wrapping modulo 2^CNT_W.
  - Beat accepted with in_last=1 → next state DONE. The result is visible one cycle after the last accept; latency last-accept→out_valid = 1 clk.
  - in_valid=0 → state and counters hold.
- DONE:
  - in_ready=0, out_valid=1.
  - out_sum=acc, out_carries=carry_cnt, out_ops=op_cnt; held stable while out_ready=0.
  - out_ready=1 → next state IDLE. Outputs retain their last values; out_valid drops.
- start is ignored outside IDLE.
- in_valid while not in ACCUM is ignored; no state change.
- Arithmetic: sum is modulo 2^WIDTH; overflow is reported only through carry_cnt.
- Single-operand group (first beat has in_last=1): out_sum=in_data, out_ops=1.
- Back-to-back operation: a start pulse in the cycle right after DONE→IDLE is honoured, giving a minimum 1-cycle IDLE gap.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: an accepted beat with add_cout=1 sets acc to all-ones (16'hFFFF) instead of add_sum. Later beats keep adding from the saturated value. carry_cnt still increments.
- Undefined: wrap-around accumulation as described in Behaviour.

Test Plan:
- Reset, then start; stream 3237, 1172, 2434 (last on 2434), out_ready=1 → out_valid one cycle after the last accept; out_sum=6843, out_carries=0, out_ops=3.
- Stream 61421, 6431 (last) → out_sum=2316, out_carries=1, out_ops=2; with ACC_SATURATE_EN defined, out_sum=65535.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid stays 1 and outputs stay stable; in_ready=0; no further beats are accepted.
- Single beat 122 with in_last=1 → out_sum=122, out_ops=1. Then a second group of 12 and 2434 → out_sum=2446, with the accumulator clean from the previous group.
- Assert rst_n=0 after 2 accepted beats → next cycle state is IDLE with all outputs 0. A following start and group of 6431, 3000 → out_sum=9431.
- in_valid pulsed with gaps (valid 1,0,0,1) plus a start pulse during ACCUM → only the valid beats are accumulated and start has no effect; carry_cnt saturates at 255 when 300 overflowing beats of 65535 are streamed.

Source files
------------

// File: rtl/add_accum_16.sv
// Streaming multi-operand summer around the external 16-bit adder.
// Optional ACC_SATURATE_EN clamps the accumulator to all-ones on carry.
module add_accum_16 #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_cin,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic [CNT_W-1:0] out_carries,
   output logic [CNT_W-1:0] out_ops
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;
   logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_sum_q, out_sum_d;
   logic [CNT_W-1:0] out_carries_q, out_carries_d;
   logic [CNT_W-1:0] out_ops_q, out_ops_d;

   logic             accept;
   logic [WIDTH-1:0] beat_acc;
   logic [CNT_W-1:0] beat_carry;
   logic [CNT_W-1:0] beat_ops;

   // Adder operands come straight from the accumulator and the stream
   assign add_a   = acc_q;
   assign add_b   = in_data;
   assign add_cin = 1'b0;

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_sum     = out_sum_q;
   assign out_carries = out_carries_q;
   assign out_ops     = out_ops_q;

   // Per-beat update values: new accumulator and both counters
   always_comb begin
      accept = (state_q == ACCUM) && in_valid;
`ifdef ACC_SATURATE_EN
      beat_acc = add_cout ? {WIDTH{1'b1}} : add_sum;
`else
      beat_acc = add_sum;
`endif
      if (carry_cnt_q == {CNT_W{1'b1}}) begin
         beat_carry = carry_cnt_q;
      end else begin
         beat_carry = carry_cnt_q + {{(CNT_W-1){1'b0}}, add_cout};
      end
      beat_ops = op_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   // Next-state logic for the group FSM and the result registers
   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      carry_cnt_d   = carry_cnt_q;
      op_cnt_d      = op_cnt_q;
      out_sum_d     = out_sum_q;
      out_carries_d = out_carries_q;
      out_ops_d     = out_ops_q;
      unique case (1'b1)
         (state_q == IDLE): begin
            if (start) begin
               acc_d       = '0;
               carry_cnt_d = '0;
               op_cnt_d    = '0;
               state_d     = ACCUM;
            end
         end
         (state_q == ACCUM): begin
            if (accept) begin
               acc_d       = beat_acc;
               carry_cnt_d = beat_carry;
               op_cnt_d    = beat_ops;
               if (in_last) begin
                  out_sum_d     = beat_acc;
                  out_carries_d = beat_carry;
                  out_ops_d     = beat_ops;
                  state_d       = DONE;
               end
            end
         end
         (state_q == DONE): begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      in_ready_d  = (state_d == ACCUM);
      out_valid_d = (state_d == DONE);
   end

   // State and registered outputs; reset wins over everything
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         acc_q         <= '0;
         carry_cnt_q   <= '0;
         op_cnt_q      <= '0;
         in_ready_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         out_sum_q     <= '0;
         out_carries_q <= '0;
         out_ops_q     <= '0;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         carry_cnt_q   <= carry_cnt_d;
         op_cnt_q      <= op_cnt_d;
         in_ready_q    <= in_ready_d;
         out_valid_q   <= out_valid_d;
         out_sum_q     <= out_sum_d;
         out_carries_q <= out_carries_d;
         out_ops_q     <= out_ops_d;
      end
   end

endmodule

// File: tb/tb_add_accum_16.sv
// Scoreboard bench for add_accum_16 with a behavioural adder.
// Expected group results come from a plain-arithmetic model.
module tb_add_accum_16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        in_last = 1'b0;
   logic [15:0] add_a;
   logic [15:0] add_b;
   logic        add_cin;
   logic [15:0] add_sum;
   logic        add_cout;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_sum;
   logic [7:0]  out_carries;
   logic [7:0]  out_ops;

   logic [16:0] add_res;

   add_accum_16 #(.WIDTH(16), .CNT_W(8)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_last(in_last),
      .add_a(add_a),
      .add_b(add_b),
      .add_cin(add_cin),
      .add_sum(add_sum),
      .add_cout(add_cout),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum(out_sum),
      .out_carries(out_carries),
      .out_ops(out_ops)
   );

   // Behavioural stand-in for the 16-bit adder
   assign add_res  = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
   assign add_sum  = add_res[15:0];
   assign add_cout = add_res[16];

   always #5 clk = ~clk;

   typedef struct {
      int sum;
      int car;
      int ops;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Group result from the arithmetic rules of the block
   function automatic exp_t model(input int ops[$]);
      exp_t e;
      int acc = 0;
      int car = 0;
      foreach (ops[i]) begin
         acc = acc + ops[i];
         if (acc > 65535) begin
            if (car < 255) car = car + 1;
`ifdef ACC_SATURATE_EN
            acc = 65535;
`else
            acc = acc - 65536;
`endif
         end
      end
      e.sum = acc;
      e.car = car;
      e.ops = ops.size() % 256;
      return e;
   endfunction

   // Monitor: compare whenever a result is handed off
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_sum", int'(out_sum), e.sum);
            chk("out_carries", int'(out_carries), e.car);
            chk("out_ops", int'(out_ops), e.ops);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic beat(input int d, input bit last);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d[15:0];
      in_last  = last;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 50) begin
            chk("in_ready_timeout", 0, 1);
            break;
         end
      end
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_group(input int ops[$], output exp_t e);
      e = model(ops);
      sb.push_back(e);
      do_start();
      foreach (ops[i]) beat(ops[i], i == ops.size() - 1);
      @(negedge clk);
      chk("latency_out_valid", int'(out_valid), 1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("drain", sb.size(), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int q[$];
      exp_t e;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_sum", int'(out_sum), 0);
      chk("rst_out_ops", int'(out_ops), 0);
      chk("add_cin", int'(add_cin), 0);
      rst_n = 1'b1;

      q = '{3237, 1172, 2434};
      send_group(q, e);
      wait_drain();

      // Backpressure with ignored stray beats
      out_ready = 1'b0;
      q = '{61421, 6431};
      send_group(q, e);
      in_valid = 1'b1;
      in_data  = 16'd999;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", int'(out_valid), 1);
         chk("bp_out_sum", int'(out_sum), e.sum);
         chk("bp_out_carries", int'(out_carries), e.car);
         chk("bp_in_ready", int'(in_ready), 0);
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b1;
      wait_drain();
      @(negedge clk);
      chk("idle_out_valid", int'(out_valid), 0);
      chk("idle_out_sum_kept", int'(out_sum), e.sum);
      chk("idle_out_ops_kept", int'(out_ops), e.ops);

      q = '{122};
      send_group(q, e);
      wait_drain();
      q = '{12, 2434};
      send_group(q, e);
      wait_drain();

      // Reset in the middle of a group
      do_start();
      beat(6431, 1'b0);
      beat(3000, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_rst_in_ready", int'(in_ready), 0);
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_out_sum", int'(out_sum), 0);
      chk("mid_rst_out_carries", int'(out_carries), 0);
      chk("mid_rst_out_ops", int'(out_ops), 0);
      rst_n = 1'b1;
      q = '{6431, 3000};
      send_group(q, e);
      wait_drain();

      // Valid gaps plus a stray start while accumulating
      q = '{100, 200};
      e = model(q);
      sb.push_back(e);
      do_start();
      beat(100, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      beat(200, 1'b1);
      wait_drain();

      // Carry counter saturation
      q = {};
      for (int i = 0; i < 300; i++) q.push_back(65535);
      send_group(q, e);
      wait_drain();

      // Random groups
      for (int g = 0; g < 8; g++) begin
         int n;
         n = $urandom_range(1, 6);
         q = {};
         for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(0, 65535)));
         send_group(q, e);
         wait_drain();
      end

      repeat (3) @(negedge clk);
      chk("final_sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
